// File: rtl/dbus_bridge_ctrl_pkg.sv
// Shared types for the UART <-> dbus bridge: mode codes, channel states and the
// mode-to-route map used by the top level.
package dbus_bridge_ctrl_pkg;

    typedef enum logic [1:0] {
        ModeBridge   = 2'b00,
        ModeUartLoop = 2'b01,
        ModeDbusLoop = 2'b10,
        ModeHalt     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAck   = 2'b01,
        StFault = 2'b10
    } ch_state_e;

    // down = UART RX source, up = dbus source; *_dbus selects the dbus sink, else UART TX.
    typedef struct packed {
        logic down_en;
        logic down_dbus;
        logic up_en;
        logic up_dbus;
    } route_t;

    function automatic route_t route_of(input mode_e mode);
        route_t r;
        r = '0;
        case (mode)
            ModeBridge: begin
                r.down_en   = 1'b1;
                r.down_dbus = 1'b1;
                r.up_en     = 1'b1;
            end
            ModeUartLoop: r.down_en = 1'b1;
            ModeDbusLoop: begin
                r.up_en   = 1'b1;
                r.up_dbus = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dbus_bridge_ctrl_if.sv
// Bus bundle between the bridge controller and the FIFOs / dbus engine around it.
// The master modport is the controller's view.
interface dbus_bridge_ctrl_if
    import dbus_bridge_ctrl_pkg::*;
#(
    parameter int unsigned c_LEVELWIDTH = 13,
    parameter int unsigned c_CNTWIDTH   = 16
);
    mode_e                   i_mode;
    logic                    i_clear;
    logic                    i_rx_avail;
    logic [7:0]              i_rx_data;
    logic                    o_rx_read;
    logic [c_LEVELWIDTH-1:0] i_rx_level;
    logic                    o_cts;
    logic [7:0]              o_dbus_data;
    logic                    o_dbus_enable;
    logic                    i_dbus_busy;
    logic [7:0]              i_dbus_data;
    logic                    i_dbus_avail;
    logic                    o_dbus_read;
    logic [7:0]              o_tx_data;
    logic                    o_tx_enable;
    logic                    i_tx_busy;
    logic [1:0]              o_fault;
    logic [c_CNTWIDTH-1:0]   o_down_count;
    logic [c_CNTWIDTH-1:0]   o_up_count;

    modport master (
        input  i_mode, i_clear, i_rx_avail, i_rx_data, i_rx_level, i_dbus_busy,
               i_dbus_data, i_dbus_avail, i_tx_busy,
        output o_rx_read, o_cts, o_dbus_data, o_dbus_enable, o_dbus_read, o_tx_data,
               o_tx_enable, o_fault, o_down_count, o_up_count
    );

    modport slave (
        output i_mode, i_clear, i_rx_avail, i_rx_data, i_rx_level, i_dbus_busy,
               i_dbus_data, i_dbus_avail, i_tx_busy,
        input  o_rx_read, o_cts, o_dbus_data, o_dbus_enable, o_dbus_read, o_tx_data,
               o_tx_enable, o_fault, o_down_count, o_up_count
    );

endinterface

// File: rtl/dbus_bridge_ctrl_hs_channel.sv
// One four-phase channel: waits for a byte, holds read/strobe until the source drops avail,
// then counts it. A source that never drops avail is abandoned after c_TIMEOUT cycles.
module dbus_bridge_ctrl_hs_channel
    import dbus_bridge_ctrl_pkg::*;
#(
    parameter int unsigned c_TIMEOUT  = 65535,
    parameter int unsigned c_CNTWIDTH = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_avail,
    input  logic [7:0]            i_data,
    input  logic                  i_sink_busy,
    input  logic                  i_permit,
    output logic                  o_read,
    output logic                  o_strobe,
    output logic [7:0]            o_data,
    output logic                  o_idle,
    output logic                  o_fault_set,
    output logic [c_CNTWIDTH-1:0] o_count
);

    localparam int unsigned TmrW = (c_TIMEOUT > 1) ? $clog2(c_TIMEOUT) : 1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'((c_TIMEOUT == 0) ? 0 : c_TIMEOUT - 1);
    localparam logic TimeoutEn = (c_TIMEOUT != 0);

    ch_state_e             state_q, state_d;
    logic [7:0]            data_q, data_d;
    logic [TmrW-1:0]       tmr_q, tmr_d;
    logic [c_CNTWIDTH-1:0] count_q, count_d;
    logic                  done;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            data_q  <= 8'h00;
            tmr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tmr_q   <= tmr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        tmr_d       = tmr_q;
        done        = 1'b0;
        o_fault_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_avail && !i_sink_busy && i_permit) begin
                    state_d = StAck;
                    data_d  = i_data;
                    tmr_d   = '0;
                end
            end
            StAck: begin
                if (!i_avail) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end else if (TimeoutEn && (tmr_q == TmrLast)) begin
                    state_d     = StFault;
                    o_fault_set = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StFault: begin
                if (!i_avail) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear wins over a completion landing in the same cycle.
        if (i_clear) begin
            count_d = '0;
        end else if (done) begin
            count_d = count_q + 1'b1;
        end else begin
            count_d = count_q;
        end
    end

    assign o_read   = (state_q == StAck);
    assign o_strobe = (state_q == StAck);
    assign o_data   = data_q;
    assign o_idle   = (state_q == StIdle);
    assign o_count  = count_q;

endmodule

// File: rtl/dbus_bridge_ctrl.sv
// Flow-control core between the UART RX/TX FIFOs and the dbus engine: input sampling,
// mode latch and routing, CTS hysteresis, sticky timeout faults and byte counters.
module dbus_bridge_ctrl
    import dbus_bridge_ctrl_pkg::*;
#(
    parameter int unsigned c_LEVELWIDTH = 13,
    parameter int unsigned c_CTS_HI     = 7936,
    parameter int unsigned c_CTS_LO     = 6144,
    parameter int unsigned c_TIMEOUT    = 65535,
    parameter int unsigned c_CNTWIDTH   = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    dbus_bridge_ctrl_if.master bus
);

    localparam logic [c_LEVELWIDTH-1:0] CtsHi = c_LEVELWIDTH'(c_CTS_HI);
    localparam logic [c_LEVELWIDTH-1:0] CtsLo = c_LEVELWIDTH'(c_CTS_LO);

    logic       rx_avail_q, dbus_avail_q, dbus_busy_q, tx_busy_q;
    mode_e      mode_q, mode_d;
    route_t     rt_q, rt_d;
    logic       cts_q, cts_d;
    logic [1:0] fault_q, fault_d;

    logic                  down_read, down_strobe, down_idle, down_fault;
    logic                  up_read, up_strobe, up_idle, up_fault;
    logic [7:0]            down_data, up_data;
    logic [c_CNTWIDTH-1:0] down_count, up_count;
    logic                  down_busy, up_busy;
    logic                  down_to_dbus, down_to_tx, up_to_dbus, up_to_tx;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_avail_q   <= 1'b0;
            dbus_avail_q <= 1'b0;
            dbus_busy_q  <= 1'b0;
            tx_busy_q    <= 1'b0;
            mode_q       <= ModeHalt;
            cts_q        <= 1'b1;
            fault_q      <= 2'b00;
        end else begin
            rx_avail_q   <= bus.i_rx_avail;
            dbus_avail_q <= bus.i_dbus_avail;
            dbus_busy_q  <= bus.i_dbus_busy;
            tx_busy_q    <= bus.i_tx_busy;
            mode_q       <= mode_d;
            cts_q        <= cts_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        // A new mode only takes over while both channels rest, so a byte in flight finishes
        // on the route it started on; channels launch with the route that will be latched.
        mode_d    = (down_idle && up_idle) ? bus.i_mode : mode_q;
        rt_d      = route_of(mode_d);
        rt_q      = route_of(mode_q);
        down_busy = rt_d.down_dbus ? dbus_busy_q : tx_busy_q;
        up_busy   = rt_d.up_dbus ? dbus_busy_q : tx_busy_q;

        cts_d = cts_q;
        if (bus.i_rx_level >= CtsHi) begin
            cts_d = 1'b1;
        end else if (bus.i_rx_level <= CtsLo) begin
            cts_d = 1'b0;
        end

        fault_d[0] = down_fault ? 1'b1 : (bus.i_clear ? 1'b0 : fault_q[0]);
        fault_d[1] = up_fault ? 1'b1 : (bus.i_clear ? 1'b0 : fault_q[1]);
    end

    dbus_bridge_ctrl_hs_channel #(
        .c_TIMEOUT (c_TIMEOUT),
        .c_CNTWIDTH(c_CNTWIDTH)
    ) u_down (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (bus.i_clear),
        .i_avail    (rx_avail_q),
        .i_data     (bus.i_rx_data),
        .i_sink_busy(down_busy),
        .i_permit   (rt_d.down_en),
        .o_read     (down_read),
        .o_strobe   (down_strobe),
        .o_data     (down_data),
        .o_idle     (down_idle),
        .o_fault_set(down_fault),
        .o_count    (down_count)
    );

    dbus_bridge_ctrl_hs_channel #(
        .c_TIMEOUT (c_TIMEOUT),
        .c_CNTWIDTH(c_CNTWIDTH)
    ) u_up (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (bus.i_clear),
        .i_avail    (dbus_avail_q),
        .i_data     (bus.i_dbus_data),
        .i_sink_busy(up_busy),
        .i_permit   (rt_d.up_en),
        .o_read     (up_read),
        .o_strobe   (up_strobe),
        .o_data     (up_data),
        .o_idle     (up_idle),
        .o_fault_set(up_fault),
        .o_count    (up_count)
    );

    assign down_to_dbus = rt_q.down_en & rt_q.down_dbus;
    assign down_to_tx   = rt_q.down_en & ~rt_q.down_dbus;
    assign up_to_dbus   = rt_q.up_en & rt_q.up_dbus;
    assign up_to_tx     = rt_q.up_en & ~rt_q.up_dbus;

    assign bus.o_rx_read     = down_read;
    assign bus.o_dbus_read   = up_read;
    assign bus.o_dbus_enable = (down_to_dbus & down_strobe) | (up_to_dbus & up_strobe);
    assign bus.o_dbus_data   = down_to_dbus ? down_data : (up_to_dbus ? up_data : 8'h00);
    assign bus.o_tx_enable   = (down_to_tx & down_strobe) | (up_to_tx & up_strobe);
    assign bus.o_tx_data     = down_to_tx ? down_data : (up_to_tx ? up_data : 8'h00);
    assign bus.o_cts         = cts_q;
    assign bus.o_fault       = fault_q;
    assign bus.o_down_count  = down_count;
    assign bus.o_up_count    = up_count;

    // The route map never points both channels at one sink, so no arbiter exists.
    a_no_contention: assert property (@(posedge i_clock) disable iff (i_reset)
        !(down_to_dbus && up_to_dbus) && !(down_to_tx && up_to_tx));

endmodule

// File: tb/tb_dbus_bridge_ctrl.sv
// Randomised bench for dbus_bridge_ctrl: transaction-level source/sink agents checked
// against a routing table, handshake latencies, a byte-count model and a CTS model.
module tb_dbus_bridge_ctrl;
    import dbus_bridge_ctrl_pkg::*;

    localparam int unsigned LW = 13;
    localparam int unsigned CW = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned HI = 7936;
    localparam int unsigned LO = 6144;
    localparam int SinkNone = 0;
    localparam int SinkDbus = 1;
    localparam int SinkTx   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dbus_bridge_ctrl_if #(.c_LEVELWIDTH(LW), .c_CNTWIDTH(CW)) bus ();

    dbus_bridge_ctrl #(
        .c_LEVELWIDTH(LW),
        .c_CTS_HI    (HI),
        .c_CTS_LO    (LO),
        .c_TIMEOUT   (TO),
        .c_CNTWIDTH  (CW)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int    n_vec = 0;
    int    n_err = 0;
    int    cnt_m[2];
    mode_e cur_mode;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Where each source's bytes should land in each mode.
    function automatic int sink_of(input int chan, input mode_e m);
        if (chan == 0) return (m == ModeBridge) ? SinkDbus : (m == ModeUartLoop) ? SinkTx : SinkNone;
        return (m == ModeBridge) ? SinkTx : (m == ModeDbusLoop) ? SinkDbus : SinkNone;
    endfunction

    function automatic logic read_of(input int chan);
        return (chan == 0) ? bus.o_rx_read : bus.o_dbus_read;
    endfunction

    function automatic logic en_of(input int sink);
        return (sink == SinkDbus) ? bus.o_dbus_enable : (sink == SinkTx) ? bus.o_tx_enable : 1'b0;
    endfunction

    function automatic logic [7:0] data_of(input int sink);
        return (sink == SinkDbus) ? bus.o_dbus_data : bus.o_tx_data;
    endfunction

    function automatic logic [31:0] count_of(input int chan);
        return (chan == 0) ? 32'(bus.o_down_count) : 32'(bus.o_up_count);
    endfunction

    function automatic logic [31:0] cnt_exp(input int chan);
        return 32'(cnt_m[chan] % (1 << CW));
    endfunction

    task automatic set_src(input int chan, input logic avail, input logic [7:0] data);
        if (chan == 0) begin
            bus.i_rx_avail = avail;
            bus.i_rx_data  = data;
        end else begin
            bus.i_dbus_avail = avail;
            bus.i_dbus_data  = data;
        end
    endtask

    task automatic set_busy(input int sink, input logic v);
        if (sink == SinkDbus) bus.i_dbus_busy = v;
        else if (sink == SinkTx) bus.i_tx_busy = v;
    endtask

    task automatic set_mode(input mode_e m);
        bus.i_mode = m;
        cur_mode   = m;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
    endtask

    // Cycles until read reaches lvl, or -1 if it does not within max.
    task automatic wait_level(input int chan, input logic lvl, input int max, output int lat);
        lat = -1;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (read_of(chan) == lvl) begin
                lat = c;
                break;
            end
        end
    endtask

    // One byte through a channel; sink held busy for busy_k cycles, avail held hold cycles
    // past the read. Sampling adds one cycle on each edge of the handshake.
    task automatic xfer(input int chan, input logic [7:0] b, input int busy_k, input int hold);
        int   sink, other, lat;
        logic seen;
        sink = sink_of(chan, cur_mode);
        set_src(chan, 1'b1, b);
        if (sink == SinkNone) begin
            seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                seen |= read_of(chan);
            end
            check_eq("unrouted_read", 32'(seen), 0);
            set_src(chan, 1'b0, 8'h00);
            repeat (3) @(negedge clk);
            check_eq("unrouted_count", count_of(chan), cnt_exp(chan));
            return;
        end
        other = (sink == SinkDbus) ? SinkTx : SinkDbus;
        if (busy_k > 0) set_busy(sink, 1'b1);
        lat = -1;
        for (int c = 1; c <= busy_k + 10; c++) begin
            @(negedge clk);
            if (read_of(chan)) begin
                lat = c;
                break;
            end
            if (c == busy_k) set_busy(sink, 1'b0);
        end
        set_busy(sink, 1'b0);
        check_eq("rise_latency", 32'(lat), 32'(busy_k + 2));
        check_eq("sink_enable", 32'(en_of(sink)), 1);
        check_eq("sink_data", 32'(data_of(sink)), 32'(b));
        check_eq("other_enable", 32'(en_of(other)), 0);
        repeat (hold) @(negedge clk);
        set_src(chan, 1'b0, b);
        wait_level(chan, 1'b0, 10, lat);
        check_eq("fall_latency", 32'(lat), 2);
        cnt_m[chan]++;
        check_eq("sink_enable_off", 32'(en_of(sink)), 0);
        check_eq(chan == 0 ? "down_count" : "up_count", count_of(chan), cnt_exp(chan));
        if (lat < 0) repeat (TO + 4) @(negedge clk);
    endtask

    int   lat, hi, lvl;
    logic cts_m;

    initial begin
        cnt_m[0]         = 0;
        cnt_m[1]         = 0;
        cur_mode         = ModeBridge;
        bus.i_mode       = ModeBridge;
        bus.i_clear      = 1'b0;
        bus.i_rx_avail   = 1'b0;
        bus.i_rx_data    = 8'h00;
        bus.i_rx_level   = '0;
        bus.i_dbus_busy  = 1'b0;
        bus.i_dbus_data  = 8'h00;
        bus.i_dbus_avail = 1'b0;
        bus.i_tx_busy    = 1'b0;
        rst              = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_rx_read", 32'(bus.o_rx_read), 0);
        check_eq("rst_dbus_enable", 32'(bus.o_dbus_enable), 0);
        check_eq("rst_dbus_read", 32'(bus.o_dbus_read), 0);
        check_eq("rst_tx_enable", 32'(bus.o_tx_enable), 0);
        check_eq("rst_fault", 32'(bus.o_fault), 0);
        check_eq("rst_down_count", 32'(bus.o_down_count), 0);
        check_eq("rst_up_count", 32'(bus.o_up_count), 0);
        check_eq("rst_cts", 32'(bus.o_cts), 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("cts_first_compare", 32'(bus.o_cts), 0);
        @(negedge clk);

        // Directed bridge traffic, including a long sink stall on each side.
        xfer(0, 8'h5A, 0, 2);
        xfer(1, 8'($urandom), 0, 1);
        xfer(0, 8'hA5, 105, 1);
        xfer(1, 8'($urandom), 3, 0);

        // CTS hysteresis against the set/clear/hold rule.
        cts_m = 1'b0;
        for (int i = 0; i < 64; i++) begin
            case (i)
                0: lvl = 7935;
                1: lvl = 7936;
                2: lvl = 7000;
                3: lvl = 6144;
                4: lvl = 6145;
                default: lvl = $urandom_range(5900, 8191);
            endcase
            bus.i_rx_level = LW'(lvl);
            @(negedge clk);
            if (lvl >= HI) cts_m = 1'b1;
            else if (lvl <= LO) cts_m = 1'b0;
            check_eq("cts", 32'(bus.o_cts), 32'(cts_m));
        end
        bus.i_rx_level = '0;
        @(negedge clk);

        // Mode change while a byte is in flight: it finishes on the bridge route.
        set_mode(ModeBridge);
        set_src(0, 1'b1, 8'h96);
        wait_level(0, 1'b1, 10, lat);
        check_eq("mc_rise", 32'(lat), 2);
        bus.i_mode = ModeUartLoop;
        repeat (2) @(negedge clk);
        check_eq("mc_dbus_enable", 32'(bus.o_dbus_enable), 1);
        check_eq("mc_dbus_data", 32'(bus.o_dbus_data), 32'h96);
        check_eq("mc_tx_enable", 32'(bus.o_tx_enable), 0);
        set_src(0, 1'b0, 8'h96);
        wait_level(0, 1'b0, 10, lat);
        cnt_m[0]++;
        check_eq("mc_count", count_of(0), cnt_exp(0));
        cur_mode = ModeUartLoop;
        @(negedge clk);
        xfer(0, 8'h33, 0, 1);

        // Down-channel timeout, then clear.
        set_mode(ModeBridge);
        set_src(0, 1'b1, 8'hC3);
        wait_level(0, 1'b1, 10, lat);
        check_eq("to_rise", 32'(lat), 2);
        hi = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.o_rx_read) break;
            hi++;
        end
        check_eq("to_read_cycles", 32'(hi), 32'(TO));
        check_eq("to_fault", 32'(bus.o_fault), 32'b01);
        check_eq("to_enable", 32'(bus.o_dbus_enable), 0);
        check_eq("to_count", count_of(0), cnt_exp(0));
        pulse_clear();
        check_eq("clr_fault", 32'(bus.o_fault), 0);
        check_eq("clr_down_count", count_of(0), 0);
        check_eq("clr_up_count", count_of(1), 0);
        set_src(0, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        check_eq("to_release_read", 32'(bus.o_rx_read), 0);
        check_eq("to_release_count", count_of(0), 0);

        // Up-channel timeout on the same edge as a clear: the new fault survives.
        set_src(1, 1'b1, 8'h3C);
        wait_level(1, 1'b1, 10, lat);
        repeat (TO - 1) @(negedge clk);
        check_eq("to_up_still_high", 32'(bus.o_dbus_read), 1);
        pulse_clear();
        check_eq("to_up_read", 32'(bus.o_dbus_read), 0);
        check_eq("to_up_fault_wins", 32'(bus.o_fault), 32'b10);
        pulse_clear();
        check_eq("to_up_cleared", 32'(bus.o_fault), 0);
        set_src(1, 1'b0, 8'h00);
        repeat (4) @(negedge clk);

        // Random modes, channels, stalls and hold times.
        for (int i = 0; i < 40; i++) begin
            set_mode(mode_e'($urandom_range(0, 3)));
            xfer($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
        end

        // Counter wrap after 2^CW bytes.
        set_mode(ModeUartLoop);
        pulse_clear();
        for (int i = 0; i < (1 << CW); i++) xfer(0, 8'($urandom), 0, 0);
        check_eq("wrap_count", count_of(0), 0);

        // Reset mid-handshake: the byte is dropped and outputs return to reset values.
        set_mode(ModeBridge);
        xfer(0, 8'h42, 0, 0);
        set_src(0, 1'b1, 8'h77);
        wait_level(0, 1'b1, 10, lat);
        rst = 1'b1;
        set_src(0, 1'b0, 8'h00);
        @(negedge clk);
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        check_eq("rstack_read", 32'(bus.o_rx_read), 0);
        check_eq("rstack_enable", 32'(bus.o_dbus_enable), 0);
        check_eq("rstack_data", 32'(bus.o_dbus_data), 0);
        check_eq("rstack_count", count_of(0), 0);
        check_eq("rstack_cts", 32'(bus.o_cts), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        xfer(0, 8'h11, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
